// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for prio_arbiter_n (ARB_TIMEOUT_EN is handled in the top)
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index width that stays at least one bit for degenerate sizes
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_arbiter_n_if.sv
// rtl/prio_arbiter_n_if.sv - requester/arbiter bundle: req, prio, gnt, gnt_id, busy
interface prio_arbiter_n_if #(
  parameter int N  = 4,
  parameter int PW = 2
);
  import arb_pkg::*;

  localparam int IW = idx_w(N);

  logic [N-1:0]    req;
  logic [N*PW-1:0] prio;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            busy;

  modport master (output req, prio, input gnt, gnt_id, busy);
  modport slave  (input req, prio, output gnt, gnt_id, busy);

endinterface

// File: rtl/prio_arbiter_n_prio_select.sv
// rtl/prio_arbiter_n_prio_select.sv - combinational winner pick: highest prio, ties to lowest index
module prio_select
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]    cand,
  input  logic [N*PW-1:0] prio,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [PW-1:0] best;

  // Strict compare while scanning upward keeps the lowest index on ties
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && (!valid || (prio[i*PW +: PW] > best))) begin
        valid = 1'b1;
        idx   = IW'(i);
        best  = prio[i*PW +: PW];
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_n.sv
// rtl/prio_arbiter_n.sv - non-preemptive N-way priority arbiter; ARB_TIMEOUT_EN adds a hold-limit handoff
module prio_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int PW       = 2,
  parameter int MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst,
  prio_arbiter_n_if.slave bus
);

  localparam int IW = idx_w(N);

  if (N < 2 || N > 16) begin : g_n_check
    $error("N must be in 2..16");
  end
  if (MAX_HOLD < 2) begin : g_hold_check
    $error("MAX_HOLD must be >= 2");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;

  logic [N-1:0]  cand;
  logic [N-1:0]  owner_oh;
  logic [15:0]   owner16, sel16;
  logic [IW-1:0] sel_idx;
  logic          sel_valid;
  logic          owner_req;
  logic          timeout;
  logic          new_grant;

  always_comb begin
    owner16   = onehot16(4'(gnt_id_q));
    sel16     = onehot16(4'(sel_idx));
    owner_oh  = owner16[N-1:0];
    owner_req = |(bus.req & owner_oh);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = idx_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_q, hold_d;

  assign timeout = (state_q == GRANT) && (hold_q == HOLD_MAX) && owner_req
                   && (|(bus.req & ~owner_oh));

  always_comb begin
    hold_d = hold_q;
    if (new_grant || (state_d == IDLE)) begin
      hold_d = '0;
    end else if ((state_q == GRANT) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // A timed-out owner is excluded so the handoff cannot re-pick it
  assign cand = timeout ? (bus.req & ~owner_oh) : bus.req;

  prio_select #(
    .N  (N),
    .PW (PW)
  ) u_prio_select (
    .cand  (cand),
    .prio  (bus.prio),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (owner_req && !timeout) begin
          state_d = GRANT;
        end else if (sel_valid) begin
          new_grant = 1'b1;
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
    if (new_grant) begin
      state_d  = GRANT;
      gnt_d    = sel16[N-1:0];
      gnt_id_d = sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = |gnt_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// tb/tb_prio_arbiter_n.sv - scoreboard bench for prio_arbiter_n (N=4, PW=2, MAX_HOLD=4), ARB_TIMEOUT_EN aware
module tb_prio_arbiter_n;

  logic clk;
  logic rst;

  int tests = 0;
  int fails = 0;

  logic [3:0] sb[$];

  prio_arbiter_n_if #(.N(4), .PW(2)) bus ();

  prio_arbiter_n #(
    .N        (4),
    .PW       (2),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] exp_gnt);
    tests++;
    if (bus.gnt !== exp_gnt) begin
      fails++;
      $display("FAIL %s: gnt got %b want %b", name, bus.gnt, exp_gnt);
    end
    tests++;
    if (bus.gnt_id !== oh_to_idx(exp_gnt)) begin
      fails++;
      $display("FAIL %s: gnt_id got %0d want %0d", name, bus.gnt_id, oh_to_idx(exp_gnt));
    end
    tests++;
    if (bus.busy !== (|exp_gnt)) begin
      fails++;
      $display("FAIL %s: busy got %b want %b", name, bus.busy, |exp_gnt);
    end
  endtask

  // Monitor: one expected grant per clock, compared just after the edge
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (rst && (sb.size() > 0)) begin
      e = sb.pop_front();
      check("sb", e);
    end
  end

  task automatic step(input logic [3:0] r, input logic [3:0] exp_gnt);
    @(negedge clk);
    bus.req = r;
    sb.push_back(exp_gnt);
  endtask

  initial begin
    rst      = 1'b0;
    bus.req  = 4'b1111;
    bus.prio = 8'h00;
    #12;
    check("reset_hold", 4'b0000);

    @(negedge clk);
    rst     = 1'b1;
    bus.req = 4'b0000;

    step(4'b0000, 4'b0000);
    // single request and release
    step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);
    // req3 has top priority
    bus.prio = 8'b11_00_00_00;
    step(4'b1001, 4'b1000);
    step(4'b0000, 4'b0000);
    // equal priority tie goes to lowest index
    bus.prio = 8'h00;
    step(4'b1010, 4'b0010);
    step(4'b0000, 4'b0000);
    bus.prio = 8'hFF;
    step(4'b1110, 4'b0010);
    step(4'b0000, 4'b0000);
    // no preemption, then direct handoff
    bus.prio = 8'h00;
    step(4'b0001, 4'b0001);
    bus.prio = 8'b11_00_00_00;
    step(4'b1001, 4'b0001);
    step(4'b1001, 4'b0001);
    step(4'b1000, 4'b1000);
    step(4'b0000, 4'b0000);
    // single-cycle simultaneous pulse
    bus.prio = 8'h00;
    step(4'b0011, 4'b0001);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    // owner drop with several waiting: req2 prio 2 beats req1 prio 1
    bus.prio = 8'b00_10_01_00;
    step(4'b0001, 4'b0001);
    step(4'b0110, 4'b0100);
    step(4'b0010, 4'b0010);
    step(4'b0000, 4'b0000);
    // hold limit with a competitor waiting
    bus.prio = 8'h00;
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_TIMEOUT_EN
      step(4'b0101, (i < 4) ? 4'b0001 : 4'b0100);
`else
      step(4'b0101, 4'b0001);
`endif
    end
    step(4'b0000, 4'b0000);
    // lone owner is never forced off
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, 4'b0001);
    end
    step(4'b0000, 4'b0000);
    // async reset in the middle of a grant
    step(4'b0010, 4'b0010);
    step(4'b0010, 4'b0010);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset_mid_grant", 4'b0000);

    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prio_arbiter_n.md
Name: prio_arbiter_n

Overview:
- N-requester, parametrised-priority arbiter; next generation of the two-requester A/B arbiter HLSM.
- Grants one shared resource to one requester at a time, with registered one-hot grant plus encoded owner index.
- Non-preemptive ownership: the owner keeps the grant while it requests.
- Sits between N bus masters and a shared slave/port.

Parameters:
- N, 4, number of requesters (2..16).
- PW, 2, width of each requester's priority field.
- MAX_HOLD, 8, max consecutive grant cycles before forced handoff; used only with ARB_TIMEOUT_EN; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  request per requester; level-sensitive.
- prio  in  N*PW  packed priorities; requester i uses bits [i*PW +: PW]; larger value wins.
- gnt  out  N  one-hot grant, registered; all-zero when idle.
- gnt_id  out  $clog2(N)  index of owner; 0 when idle.
- busy  out  1  high when any gnt bit is high.

Behaviour:
- Reset (rst=0, async): state IDLE; gnt=0, gnt_id=0, busy=0, hold counter=0. Reset takes effect immediately, mid-grant included. Release is synchronous to the next clk edge.
- States: IDLE, GRANT. All outputs come from registers, with no combinational path from req to gnt.
- Latency: a request sampled at edge k produces its grant visible after edge k. One cycle, same as the two-requester arbiter.
- Winner selection (combinational, over candidate set C):
  - Highest prio among C.
  - Ties go to the lowest index.
  - prio is sampled each cycle; changes affect only the next selection, never the current owner.
- IDLE:
  - req==0 -> stay IDLE.
  - Otherwise -> GRANT to winner over C=req.
- GRANT, owner o:
  - req[o]=1 -> stay, even if a higher-priority requester appears (no preemption).
  - req[o]=0 and other requests pending -> direct handoff next edge to winner over C=req. No idle bubble.
  - req[o]=0 and req==0 -> IDLE.
- Single-cycle request: granted for exactly one cycle, then released (or handed off).
- Simultaneous owner-drop and new requests at the same edge: handoff rule applies.
- gnt is never more than one-hot. gnt_id and busy are always consistent with gnt.
- Hold counter: clears on every new grant or IDLE entry, increments each cycle in GRANT, saturates at MAX_HOLD-1. Functional only with ARB_TIMEOUT_EN.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold counter == MAX_HOLD-1, req[o]=1, and (req & ~onehot(o)) != 0: the next edge grants the winner over C = req & ~onehot(o). The counter clears.
  - If no other requester is waiting, the owner continues and the counter stays saturated.
  - The preempted owner competes normally afterwards.
- Not defined: counter logic is absent and ownership is unbounded.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT}.
  - Helper function for $clog2-based index width.
  - onehot-from-index function.
- One sub-module, prio_select:
  - Parametrised N/PW.
  - Combinational: inputs candidate mask + prio vector; outputs winner index and valid.
  - Pure function, no state.
- Top module holds the state register, gnt/gnt_id registers, and the hold counter.

Test Plan (N=4, PW=2, MAX_HOLD=4):
- Reset: rst=0 while req=4'b1111 -> gnt=0, gnt_id=0, busy=0 immediately, without waiting for clk. Assert rst=0 mid-GRANT -> gnt=0 immediately.
- Single request: req=4'b0100 at edge k -> gnt=4'b0100, gnt_id=2 after edge k. Drop req -> gnt=0 after the next edge.
- Priority and tie-break:
  - prio={3,0,0,0} (req3=3), req=4'b1001 -> gnt=4'b1000.
  - All prio equal, req=4'b1010 -> gnt=4'b0010.
- No preemption and handoff: owner 0 holding, req becomes 4'b1001 with prio3=3 -> gnt stays 4'b0001. Then req=4'b1000 -> gnt=4'b1000 next edge, with no idle cycle.
- Single-cycle simultaneous pulse: req=4'b0011 for one cycle, equal prio -> gnt=4'b0001 for exactly one cycle, then 0.
- ARB_TIMEOUT_EN:
  - req0 held, req2 asserted -> gnt=4'b0001 for 4 cycles, then 4'b0100.
  - req0 alone held -> gnt=4'b0001 indefinitely.
  - Without the macro, the first case keeps gnt=4'b0001.
